// File: rtl/seg_scanner_if.sv
// -----------------------------------------------------------------------------
// seg_scanner_if
//
// Bundles the display-update inputs and the decoder/anode outputs of
// seg_scanner.
//   master : the producer of display content (drives value/load/masks/lz_en)
//            and the observer of the scan outputs.
//   slave  : the scanner itself.
//
// Signals
//   value      [15:0] four hex digits, [3:0] is digit 0 (rightmost)
//   load              one-cycle strobe capturing value/blank_mask/dp_mask/lz_en
//   blank_mask [3:0]  bit i = 1 forces digit i dark
//   dp_mask    [3:0]  bit i = 1 lights the decimal point of digit i
//   lz_en             enables leading-zero suppression
//   nibble     [3:0]  hex code of the active digit (decoder `in`)
//   blank             1 = decoder blanks all segments (decoder `rst`)
//   an         [3:0]  active-low anode enables
//   dp_n              active-low decimal point
//   frame_done        one-cycle pulse after digit 3's slot ends
// -----------------------------------------------------------------------------
interface seg_scanner_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic        lz_en;

  logic [3:0]  nibble;
  logic        blank;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_done;

  modport master (
    output value, load, blank_mask, dp_mask, lz_en,
    input  nibble, blank, an, dp_n, frame_done
  );

  modport slave (
    input  value, load, blank_mask, dp_mask, lz_en,
    output nibble, blank, an, dp_n, frame_done
  );
endinterface : seg_scanner_if

// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
//
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Display content is double buffered: a load goes into a pending
// register and is copied to the shown register only at a frame boundary
// (end of digit 3's slot), so a frame is never drawn from mixed content.
// Each digit slot lasts REFRESH_DIV cycles; the first DEAD_CYCLES of every
// slot keep all anodes off to suppress ghosting.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (4 .. 2**20)
//   DEAD_CYCLES  dark cycles at the start of each slot (1 .. REFRESH_DIV-1)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; release is synchronized internally
//   bus    seg_scanner_if.slave (content inputs, scan outputs)
//
// All outputs are registered and reflect the counter/digit/shown state of
// the previous cycle.
// -----------------------------------------------------------------------------
module seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_scanner_if.slave bus
);

  localparam int unsigned       CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD_CYCLES);

  // One complete set of display content; used for both buffers.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        lz_en;
  } content_t;

  // Reset content keeps every digit dark until a load has been transferred.
  localparam content_t SHOWN_RST = '{
    value:      16'h0000,
    blank_mask: 4'b1111,
    dp_mask:    4'b0000,
    lz_en:      1'b0
  };

  // ---------------------------------------------------------------------------
  // Reset release synchronizer. Reset asserts asynchronously everywhere, but
  // the scan counters only start once the release has passed two flops, so a
  // release close to a clock edge cannot split the counter state.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       run;

  assign sync_d = {sync_q[0], 1'b1};
  assign run    = sync_q[1];

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  // ---------------------------------------------------------------------------
  // Scan state and double buffer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             pend_valid_q, pend_valid_d;
  content_t         pend_q, pend_d;
  content_t         shown_q, shown_d;

  logic terminal;
  logic boundary;

  assign terminal = (cnt_q == CNT_LAST);
  assign boundary = run && terminal && (digit_q == 2'd3);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shown_d      = shown_q;

    if (run) begin
      if (terminal) begin
        cnt_d   = '0;
        digit_d = digit_q + 2'd1;   // 3 wraps to 0
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    // Transfer first, capture second: a load coinciding with the boundary
    // moves the previous pending content to the display and parks the new
    // content for the following frame.
    if (boundary && pend_valid_q) begin
      shown_d      = pend_q;
      pend_valid_d = 1'b0;
    end

    if (bus.load) begin
      pend_d       = '{value:      bus.value,
                       blank_mask: bus.blank_mask,
                       dp_mask:    bus.dp_mask,
                       lz_en:      bus.lz_en};
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      pend_valid_q <= 1'b0;
      shown_q      <= SHOWN_RST;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      pend_valid_q <= pend_valid_d;
      shown_q      <= shown_d;
    end
  end

  // NOTE: the pending buffer needs no reset; its content is only ever read
  // when pend_valid_q is set, which requires a load after reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  // ---------------------------------------------------------------------------
  // Output generation for the active digit
  // ---------------------------------------------------------------------------
  // upper_zero[d]: shown nibbles d..3 are all zero. Digit 0 is never
  // suppressed, so bit 0 stays clear.
  logic [3:0] upper_zero;
  logic [3:0] cur_nibble;
  logic       dead;
  logic       eff_blank;

  logic [3:0] nibble_q, nibble_d;
  logic       blank_q, blank_d;
  logic [3:0] an_q, an_d;
  logic       dp_n_q, dp_n_d;
  logic       frame_done_q, frame_done_d;

  always_comb begin
    upper_zero[3] = (shown_q.value[15:12] == 4'h0);
    upper_zero[2] = upper_zero[3] && (shown_q.value[11:8] == 4'h0);
    upper_zero[1] = upper_zero[2] && (shown_q.value[7:4]  == 4'h0);
    upper_zero[0] = 1'b0;
  end

  assign cur_nibble = shown_q.value[{digit_q, 2'b00} +: 4];
  assign dead       = (cnt_q < CNT_DEAD);
  assign eff_blank  = shown_q.blank_mask[digit_q]
                    | dead
                    | (shown_q.lz_en & upper_zero[digit_q]);

  always_comb begin
    nibble_d     = cur_nibble;
    blank_d      = eff_blank;
    an_d         = eff_blank ? 4'b1111 : ~(4'b0001 << digit_q);
    dp_n_d       = ~(shown_q.dp_mask[digit_q] & ~eff_blank);
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibble_q     <= 4'h0;
      blank_q      <= 1'b1;
      an_q         <= 4'b1111;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.blank      = blank_q;
  assign bus.an         = an_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule : seg_scanner

// File: tb/tb_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_scanner
//
// Self-checking bench for seg_scanner with REFRESH_DIV=8, DEAD_CYCLES=2.
// A reference model predicts every output each cycle from a running tick
// count (slot = ticks / REFRESH_DIV, phase = ticks % REFRESH_DIV) and two
// plain content records (pending, shown). Directed scenarios are followed by
// randomized loads.
// -----------------------------------------------------------------------------
module tb_seg_scanner;

  localparam int R = 8;
  localparam int D = 2;
  localparam int FRAME = 4 * R;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg_scanner_if bus ();

  seg_scanner #(
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  bm;
    logic [3:0]  dp;
    logic        lz;
  } content_t;

  int       mc;          // clock edges on which the scan has advanced
  int       es;          // edges since reset release (saturates at 3)
  content_t m_shown;
  content_t m_pend;
  bit       m_pv;

  logic [3:0] e_nib;
  logic       e_blank;
  logic [3:0] e_an;
  logic       e_dpn;
  logic       e_fd;

  // Predicts the state and outputs after the coming rising edge, using the
  // inputs currently applied.
  task automatic model_step();
    int          d;
    int          ph;
    logic [15:0] v;
    logic        bl;
    bit          en;
    if (!rst_n) begin
      mc      = 0;
      es      = 0;
      m_shown = '{16'h0000, 4'hF, 4'h0, 1'b0};
      m_pv    = 0;
      e_nib   = 4'h0;
      e_blank = 1'b1;
      e_an    = 4'hF;
      e_dpn   = 1'b1;
      e_fd    = 1'b0;
      return;
    end
    d  = (mc / R) % 4;
    ph = mc % R;
    v  = m_shown.value >> (4 * d);
    bl = m_shown.bm[d] || (ph < D) || (m_shown.lz && d >= 1 && v == 16'h0000);
    e_nib   = v[3:0];
    e_blank = bl;
    e_an    = bl ? 4'hF : 4'(15 - (1 << d));
    e_dpn   = !(m_shown.dp[d] && !bl);

    if (es < 3) es++;
    en   = (es >= 3);
    e_fd = en && (mc % FRAME == FRAME - 1);
    if (e_fd && m_pv) begin
      m_shown = m_pend;
      m_pv    = 0;
    end
    if (bus.load) begin
      m_pend = '{bus.value, bus.blank_mask, bus.dp_mask, bus.lz_en};
      m_pv   = 1;
    end
    if (en) mc++;
  endtask

  task automatic compare_outputs();
    check("nibble",     bus.nibble,     e_nib);
    check("blank",      bus.blank,      e_blank);
    check("an",         bus.an,         e_an);
    check("dp_n",       bus.dp_n,       e_dpn);
    check("frame_done", bus.frame_done, e_fd);
    check("an_onehot",  32'($countones(~bus.an) <= 1), 32'd1);
  endtask

  // One clock: predict, let the edge happen, compare at the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] bm,
                         input logic [3:0] dp, input logic lz);
    bus.value      = v;
    bus.blank_mask = bm;
    bus.dp_mask    = dp;
    bus.lz_en      = lz;
    bus.load       = 1'b1;
    tick();
    bus.load       = 1'b0;
  endtask

  // Advance until the next edge is at frame position `pos`.
  task automatic align(input string tag, input int pos);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (mc % FRAME == pos) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) check(tag, 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n          = 1'b0;
    bus.value      = 16'h0000;
    bus.load       = 1'b0;
    bus.blank_mask = 4'h0;
    bus.dp_mask    = 4'h0;
    bus.lz_en      = 1'b0;

    // Reset, then free-run dark with frame_done every 32 cycles.
    run(3);
    rst_n = 1'b1;
    run(100);

    // Plain content with a decimal point on digit 2.
    do_load(16'h1234, 4'b0000, 4'b0100, 1'b0);
    run(2 * FRAME + 8);

    // Leading-zero suppression.
    do_load(16'h0040, 4'b0000, 4'b0000, 1'b1);
    run(2 * FRAME + 8);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    run(2 * FRAME + 8);

    // Tearing: two loads inside one frame, last one wins at the boundary.
    align("align_tear", 10);
    do_load(16'hAAAA, 4'b0000, 4'b0000, 1'b0);
    run(4);
    do_load(16'hBBBB, 4'b0000, 4'b0000, 1'b0);
    run(2 * FRAME);

    // Load exactly on the boundary edge is shown one frame later.
    align("align_bound", FRAME - 1);
    do_load(16'hCCCC, 4'b0000, 4'b0001, 1'b0);
    run(3 * FRAME);

    // Asynchronous reset during digit 2's lit time.
    align("align_rst", 2 * R + 4);
    rst_n = 1'b0;
    #1;
    check("rst_async_an",     bus.an,         32'hF);
    check("rst_async_blank",  bus.blank,      32'd1);
    check("rst_async_dp_n",   bus.dp_n,       32'd1);
    check("rst_async_nibble", bus.nibble,     32'd0);
    check("rst_async_fd",     bus.frame_done, 32'd0);
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME + 4);

    // Per-digit blank mask.
    do_load(16'h5678, 4'b1010, 4'b0000, 1'b0);
    run(2 * FRAME + 8);

    // Randomized content and load timing.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.value      = 16'($urandom);
        bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        bus.dp_mask    = 4'($urandom);
        bus.lz_en      = 1'($urandom);
        bus.load       = 1'b1;
      end else begin
        bus.load       = 1'b0;
      end
      tick();
    end
    bus.load = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_seg_scanner
